// File: rtl/pmic_pkg.sv
// Shared constants for the power-management input path: parameter defaults and
// the channel assignment of the slide switches.
package pmic_pkg;
  localparam int unsigned N_CH_DEF            = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned HOLD_CYCLES_DEF     = 100_000_000;

  localparam int unsigned CH_ON = 0;
  localparam int unsigned CH_LB = 1;
  localparam int unsigned CH_LP = 2;
endpackage

// File: rtl/debounce_channel.sv
// One switch bit: two-flop synchroniser, debounce filter, registered rise/fall
// pulses and a single long-hold pulse per high period.
import pmic_pkg::*;

module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_hold
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]   HOLD_PRE = HW'(HOLD_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            stable_q, stable_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            hold_q, hold_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    // Any sample matching the accepted level restarts the stability window.
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_MAX) stable_d = sync2_q;
      else                    db_cnt_d = db_cnt_q + DB_W'(1);
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;

    hold_cnt_d = '0;
    hold_d     = 1'b0;
    // Saturating at HOLD_MAX keeps the pulse from repeating within one high period.
    if (stable_q) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);
      hold_d     = (hold_cnt_q == HOLD_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      stable_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      sync1_q    <= sw_raw;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign sw_hold   = hold_q;
endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw slide switches (on, LB, LP) into clean levels and pulses
// for the power-management FSM; one independent debounce_channel per bit.
import pmic_pkg::*;

module switch_conditioner #(
  parameter int unsigned N_CH            = N_CH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_stable,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic [N_CH-1:0] sw_hold
);
  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sw_raw    (sw_raw[g]),
      .sw_stable (sw_stable[g]),
      .sw_rise   (sw_rise[g]),
      .sw_fall   (sw_fall[g]),
      .sw_hold   (sw_hold[g])
    );
  end
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_switch_conditioner;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_stable, sw_rise, sw_fall, sw_hold;

  int checks = 0;
  int failures = 0;

  switch_conditioner #(.N_CH(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_hold   (sw_hold)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    sw_raw = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_s, exp_r;
    reset  = 1'b1;
    sw_raw = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({sw_stable, sw_rise, sw_fall, sw_hold} !== 12'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=0", i, {sw_stable, sw_rise, sw_fall, sw_hold});
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_s = (e >= 6) ? 3'b111 : 3'b000;
      exp_r = (e == 6) ? 3'b111 : 3'b000;
      checks++;
      if (sw_stable !== exp_s || sw_rise !== exp_r || sw_fall !== 3'b000) begin
        failures++;
        $display("FAIL reset_release edge=%0d stable=%b rise=%b fall=%b want stable=%b rise=%b fall=000",
                 e, sw_stable, sw_rise, sw_fall, exp_s, exp_r);
      end
    end
  endtask

  task automatic test_rise_hold();
    do_reset();
    sw_raw[0] = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      checks++;
      if (sw_stable[0] !== (e >= 5) || sw_rise[0] !== (e == 5) || sw_hold[0] !== (e == 15)) begin
        failures++;
        $display("FAIL rise_hold edge=%0d stable=%b rise=%b hold=%b want %b %b %b",
                 e, sw_stable[0], sw_rise[0], sw_hold[0], e >= 5, e == 5, e == 15);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int b = 0; b < 12; b++) begin
      sw_raw[1] = ((b / 3) % 2 == 0);
      step();
      checks++;
      if (sw_stable[1] !== 1'b0 || sw_rise[1] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_reject cyc=%0d stable=%b rise=%b want 0 0", b, sw_stable[1], sw_rise[1]);
      end
    end
    sw_raw[1] = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      checks++;
      if (sw_rise[1] !== (e == 5) || sw_stable[1] !== (e >= 5)) begin
        failures++;
        $display("FAIL bounce_settle edge=%0d rise=%b stable=%b want %b %b",
                 e, sw_rise[1], sw_stable[1], e == 5, e >= 5);
      end
    end
  endtask

  task automatic test_dropout();
    do_reset();
    sw_raw[2] = 1'b1;
    repeat (8) step();
    checks++;
    if (sw_stable[2] !== 1'b1) begin
      failures++;
      $display("FAIL dropout_pre stable=%b want 1", sw_stable[2]);
    end
    for (int c = 0; c < 12; c++) begin
      sw_raw[2] = !(c < 2);
      step();
      checks++;
      if (sw_stable[2] !== 1'b1 || sw_fall[2] !== 1'b0) begin
        failures++;
        $display("FAIL dropout cyc=%0d stable=%b fall=%b want 1 0", c, sw_stable[2], sw_fall[2]);
      end
    end
  endtask

  task automatic test_refire_hold();
    do_reset();
    sw_raw[0] = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      step();
      checks++;
      if (sw_hold[0] !== (e == 15)) begin
        failures++;
        $display("FAIL first_hold edge=%0d hold=%b want %b", e, sw_hold[0], e == 15);
      end
    end
    sw_raw[0] = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      step();
      checks++;
      if (sw_fall[0] !== (e == 5) || sw_stable[0] !== (e < 5) || sw_rise[0] !== 1'b0) begin
        failures++;
        $display("FAIL fall edge=%0d fall=%b stable=%b rise=%b want %b %b 0",
                 e, sw_fall[0], sw_stable[0], sw_rise[0], e == 5, e < 5);
      end
    end
    sw_raw[0] = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      step();
      checks++;
      if (sw_rise[0] !== (e == 5) || sw_hold[0] !== (e == 15) || sw_fall[0] !== 1'b0) begin
        failures++;
        $display("FAIL second_hold edge=%0d rise=%b hold=%b fall=%b want %b %b 0",
                 e, sw_rise[0], sw_hold[0], sw_fall[0], e == 5, e == 15);
      end
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    sw_raw[1] = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({sw_stable, sw_rise, sw_fall, sw_hold} !== 12'b0) begin
        failures++;
        $display("FAIL midcount_reset cyc=%0d got=%b want=0", i, {sw_stable, sw_rise, sw_fall, sw_hold});
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (sw_rise[1] !== (e == 6) || sw_stable[1] !== (e >= 6)) begin
        failures++;
        $display("FAIL midcount_restart edge=%0d rise=%b stable=%b want %b %b",
                 e, sw_rise[1], sw_stable[1], e == 6, e >= 6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_hold();
    test_bounce();
    test_dropout();
    test_refire_hold();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
Upstream input stage for the power-management FSM. Conditions the raw slide-switch inputs (on, LB, LP) before the FSM and counter consume them. Per channel it provides:
- two-flop synchroniser
- debounce filter
- single-cycle rise/fall pulses
- long-hold pulse
The FSM sees clean levels and edges only; raw switches never reach it directly.

Parameters:
N_CH, 3, number of switch channels (bit0=on, bit1=LB, bit2=LP)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new level; must be >= 2
HOLD_CYCLES, 100_000_000, cycles a stable-high level must persist before the hold pulse; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sw_raw  input  N_CH  raw asynchronous switch levels
sw_stable  output  N_CH  debounced level per channel
sw_rise  output  N_CH  one-cycle pulse when sw_stable goes 0->1
sw_fall  output  N_CH  one-cycle pulse when sw_stable goes 1->0
sw_hold  output  N_CH  one-cycle pulse when sw_stable has been high HOLD_CYCLES edges

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values: sync flops, debounce counters, hold counters, sw_stable, sw_rise, sw_fall and sw_hold all 0. Reset overrides every other event on the same edge.
- Channels are fully independent. Behaviour below is per channel.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 is used downstream.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES)):
  - If sync2 == sw_stable: counter <= 0.
  - If sync2 != sw_stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If sync2 != sw_stable and counter == DEBOUNCE_CYCLES-1: sw_stable <= sync2 and counter <= 0.
- Glitch rejection: any return of sync2 to sw_stable before acceptance clears the counter. A bounce train shorter than DEBOUNCE_CYCLES never changes sw_stable.
- Latency: sw_raw steady from before edge 0 means sw_stable changes on edge DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)th edge.
- Edge pulses:
  - sw_rise (sw_fall) is registered high on the same edge sw_stable goes 0->1 (1->0), and low on the next edge.
  - Rise and fall never assert together on one channel.
- Hold counter (width $clog2(HOLD_CYCLES+1)):
  - Held at 0 while sw_stable == 0.
  - Increments each edge while sw_stable == 1; saturates at HOLD_CYCLES.
  - sw_hold pulses for one cycle on the edge the count goes HOLD_CYCLES-1 -> HOLD_CYCLES, i.e. HOLD_CYCLES edges after sw_stable rose.
  - No repeat pulse until sw_stable falls and rises again.
- A fall clears the hold count on the following edge. A hold pulse already issued is not retracted.
- Reset mid-operation: all state clears. If a switch is high when reset releases, it is re-accepted through the full debounce path and produces a fresh sw_rise. The FSM relies on this to relearn switch positions.
- No combinational path from sw_raw to any output.

Decomposition:
- Shared package (pmic_pkg):
  - DEBOUNCE_CYCLES_DEF and HOLD_CYCLES_DEF defaults
  - channel index constants CH_ON=0, CH_LB=1, CH_LP=2
  - N_CH_DEF=3
- One sub-module, debounce_channel: sync + debounce + edge + hold for a single bit, instantiated N_CH times via generate.
- Top of this block is only the generate loop and port bundling.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, HOLD_CYCLES=10):
1. Reset for 3 cycles with sw_raw=3'b111, then release -> all outputs 0 during reset. sw_stable=3'b111 and sw_rise=3'b111 for one cycle on the 6th edge after release.
2. After reset release, sw_raw[0] rises at edge 0 and stays high -> sw_stable[0]=1 and sw_rise[0]=1 at edge 5, sw_rise[0]=0 at edge 6, sw_hold[0]=1 at edge 15 only.
3. sw_raw[1] bounces 1,0,1,0 for 3-cycle bursts, then settles high -> no sw_stable[1] change during bounce. Single sw_rise[1] exactly 6 edges after the final settle.
4. Stable-high channel 2 drops sw_raw[2] for 2 cycles, then returns -> sw_stable[2] stays 1, no sw_fall[2].
5. sw_raw[0] falls after sw_hold[0] has fired, then rises again -> sw_fall[0] once. Hold counter returns to 0. A second sw_hold[0] fires 10 edges after the new sw_rise[0].
6. Assert reset 2 cycles after channel 1 debounce starts counting -> no sw_rise[1] from the interrupted count. Debounce restarts after release with the full 6-edge latency.
